// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Coin hopper controller sitting on the far end of the vending controller's
// change interface. A request carries a coin count; the block pulses the
// eject solenoid once per coin, confirms each coin on the chute sensor,
// retries a coin whose sensor edge never arrives, and latches a jam after
// too many misses or when the hopper is found empty.
//
// Ports:
//   Clock          in   system clock, rising edge
//   nReset         in   asynchronous active-low reset
//   Change_Valid   in   one-cycle request strobe, samples Change_Amount
//   Change_Amount  in   coins to pay out (WIDTH bits)
//   Coin_Sense     in   synchronised chute sensor, 0->1 edge = one coin
//   Hopper_Empty   in   level, hopper has no coins
//   Jam_Clear      in   one-cycle operator clear of a latched jam
//   Coin_Eject     out  eject solenoid drive
//   Busy           out  payout in progress or jammed
//   Done           out  one-cycle pulse when a payout completes
//   Jam            out  jam / empty fault latched
//   Remaining      out  coins still owed (WIDTH bits)
//   Paid           out  coins sensed in the current payout (WIDTH bits)
//   Fsm_State      out  current controller state, for debug and checkers
//
// Request handshake: Change_Valid is a one-cycle strobe with no ready
// signal. It is accepted only while Busy = 0; a strobe seen while Busy = 1
// is dropped and never queued. Completion is reported by a one-cycle Done
// pulse, or by Jam rising and staying high until Jam_Clear.
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int WIDTH     = 5,
    parameter int EJECT_LEN = 2,
    parameter int TIMEOUT   = 8,
    parameter int GAP_LEN   = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Change_Valid,
    input  logic [WIDTH-1:0] Change_Amount,
    input  logic             Coin_Sense,
    input  logic             Hopper_Empty,
    input  logic             Jam_Clear,
    output logic             Coin_Eject,
    output logic             Busy,
    output logic             Done,
    output logic             Jam,
    output logic [WIDTH-1:0] Remaining,
    output logic [WIDTH-1:0] Paid,
    output logic [2:0]       Fsm_State
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EJECT      = 3'd1,
        S_WAIT_SENSE = 3'd2,
        S_GAP        = 3'd3,
        S_JAM        = 3'd4
    } state_t;

    // One timer serves all three timed phases, so it is sized for the longest.
    localparam int TMAX_A = (EJECT_LEN > TIMEOUT) ? EJECT_LEN : TIMEOUT;
    localparam int TMAX   = (TMAX_A > GAP_LEN) ? TMAX_A : GAP_LEN;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] EJECT_LAST   = TW'(EJECT_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_LEN - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry;
    logic            sense_q;
    logic            sense_edge;
    logic [RW-1:0]   retry_next;

    assign sense_edge = Coin_Sense & ~sense_q;
    assign retry_next = retry + RW'(1);
    assign Fsm_State  = state;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            timer      <= '0;
            retry      <= '0;
            sense_q    <= 1'b0;
            Coin_Eject <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Jam        <= 1'b0;
            Remaining  <= '0;
            Paid       <= '0;
        end else begin
            sense_q <= Coin_Sense;
            Done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Change_Valid) begin
                        if (Change_Amount == '0) begin
                            Done <= 1'b1;
                        end else begin
                            Busy      <= 1'b1;
                            Remaining <= Change_Amount;
                            Paid      <= '0;
                            retry     <= '0;
                            timer     <= '0;
                            // An empty hopper is caught before the solenoid fires.
                            if (Hopper_Empty) begin
                                state <= S_JAM;
                                Jam   <= 1'b1;
                            end else begin
                                state      <= S_EJECT;
                                Coin_Eject <= 1'b1;
                            end
                        end
                    end
                end

                S_EJECT, S_WAIT_SENSE: begin
                    // A coin seen on the chute takes priority over any
                    // phase end or timeout in the same cycle.
                    if (sense_edge) begin
                        Remaining  <= Remaining - WIDTH'(1);
                        Paid       <= Paid + WIDTH'(1);
                        retry      <= '0;
                        timer      <= '0;
                        Coin_Eject <= 1'b0;
                        if (Remaining == WIDTH'(1)) begin
                            state <= S_IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (state == S_EJECT) begin
                        if (timer == EJECT_LAST) begin
                            state      <= S_WAIT_SENSE;
                            timer      <= '0;
                            Coin_Eject <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end else begin
                        if (timer == TIMEOUT_LAST) begin
                            timer <= '0;
                            retry <= retry_next;
                            if (retry_next < RETRY_LIMIT && !Hopper_Empty) begin
                                state      <= S_EJECT;
                                Coin_Eject <= 1'b1;
                            end else begin
                                state <= S_JAM;
                                Jam   <= 1'b1;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (Hopper_Empty) begin
                            state <= S_JAM;
                            Jam   <= 1'b1;
                        end else begin
                            state      <= S_EJECT;
                            Coin_Eject <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_JAM: begin
                    // Remaining and Paid hold so the operator can read them.
                    Coin_Eject <= 1'b0;
                    if (Jam_Clear) begin
                        state     <= S_IDLE;
                        Jam       <= 1'b0;
                        Busy      <= 1'b0;
                        Remaining <= '0;
                        retry     <= '0;
                        timer     <= '0;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    Coin_Eject <= 1'b0;
                    Busy       <= 1'b0;
                    Jam        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//
// Stimulus issues change requests together with a per-attempt sensor plan
// (coin lands after d cycles, or never). A transaction-level model walks the
// plan to predict the outcome (done or jam, coins paid, coins owed, number
// of eject pulses, length of each pulse). A sensor driver reacts to each
// eject pulse by following the plan; a monitor pops predictions whenever
// the DUT reports completion or a pulse ends.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int WIDTH     = 5;
    localparam int EJECT_LEN = 2;
    localparam int TIMEOUT   = 8;
    localparam int GAP_LEN   = 1;
    localparam int MAX_RETRY = 2;
    localparam int EW        = 1 + 8 + WIDTH + WIDTH;

    logic             Clock;
    logic             nReset;
    logic             Change_Valid;
    logic [WIDTH-1:0] Change_Amount;
    logic             Coin_Sense;
    logic             Hopper_Empty;
    logic             Jam_Clear;
    logic             Coin_Eject;
    logic             Busy;
    logic             Done;
    logic             Jam;
    logic [WIDTH-1:0] Remaining;
    logic [WIDTH-1:0] Paid;
    logic [2:0]       Fsm_State;

    change_dispenser #(
        .WIDTH(WIDTH), .EJECT_LEN(EJECT_LEN), .TIMEOUT(TIMEOUT),
        .GAP_LEN(GAP_LEN), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .Clock(Clock), .nReset(nReset), .Change_Valid(Change_Valid),
        .Change_Amount(Change_Amount), .Coin_Sense(Coin_Sense),
        .Hopper_Empty(Hopper_Empty), .Jam_Clear(Jam_Clear),
        .Coin_Eject(Coin_Eject), .Busy(Busy), .Done(Done), .Jam(Jam),
        .Remaining(Remaining), .Paid(Paid), .Fsm_State(Fsm_State)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];    // {jam, ejects[7:0], paid, remaining}
    int            plen_q[$];   // expected length of each eject pulse
    logic [9:0]    plan_q[$];   // {miss, empty_after, delay[7:0]} per attempt
    logic [9:0]    cur_plan[$];
    int            last_paid = 0;

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic add_attempt(input bit miss, input bit empty_after, input int d);
        cur_plan.push_back({miss, empty_after, 8'(d)});
    endtask

    task automatic gen_plan(input int amt, input bit allow_empty);
        for (int i = 0; i < amt * MAX_RETRY; i++)
            add_attempt($urandom_range(0, 3) == 0,
                        allow_empty && ($urandom_range(0, 9) == 0),
                        $urandom_range(0, EJECT_LEN + TIMEOUT - 1));
    endtask

    // Walks the plan coin by coin: a landed coin is paid, a miss burns one
    // of MAX_RETRY attempts, running out of attempts or finding the hopper
    // empty before the next coin ends the payout as a jam.
    task automatic model(input int amt, input bit hop, output bit jam,
                         output int paid, output int rem, output int ej);
        int retries;
        int len;
        jam = 1'b0; paid = 0; rem = 0; ej = 0; retries = 0;
        if (amt == 0) begin
            paid = last_paid;
            return;
        end
        if (hop) begin
            jam = 1'b1;
            rem = amt;
            return;
        end
        foreach (cur_plan[i]) begin
            ej++;
            if (cur_plan[i][9]) begin
                plen_q.push_back(EJECT_LEN);
                retries++;
                if (retries >= MAX_RETRY) begin
                    jam = 1'b1;
                    rem = amt - paid;
                    return;
                end
            end else begin
                len = int'(cur_plan[i][7:0]) + 1;
                plen_q.push_back(len < EJECT_LEN ? len : EJECT_LEN);
                paid++;
                retries = 0;
                if (paid == amt) return;
                if (cur_plan[i][8]) begin
                    jam = 1'b1;
                    rem = amt - paid;
                    return;
                end
            end
        end
        check("plan_too_short", 1, 0);
    endtask

    // ---------------- sensor driver ----------------
    initial begin : sensor_driver
        logic [9:0] e;
        bit armed;
        bit ejp;
        bit emp_next;
        bit emp_pend;
        int cnt;
        Coin_Sense = 1'b0;
        armed = 0; ejp = 0; emp_next = 0; emp_pend = 0; cnt = 0;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                armed = 0; ejp = 0; emp_pend = 0;
                Coin_Sense = 1'b0;
            end else begin
                if (Coin_Sense) begin
                    Coin_Sense = 1'b0;
                    if (emp_pend) Hopper_Empty = 1'b1;
                    emp_pend = 0;
                end
                if (Coin_Eject && !ejp && plan_q.size() > 0) begin
                    e        = plan_q.pop_front();
                    armed    = !e[9];
                    emp_next = e[8];
                    cnt      = int'(e[7:0]);
                end
                if (armed) begin
                    if (cnt == 0) begin
                        Coin_Sense = 1'b1;
                        armed      = 0;
                        emp_pend   = emp_next;
                    end else begin
                        cnt--;
                    end
                end
                ejp = Coin_Eject;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        bit ej_prev;
        bit jam_prev;
        int ej_cnt;
        int plen;
        ej_prev = 0; jam_prev = 0; ej_cnt = 0; plen = 0;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                ej_prev = 0; jam_prev = 0; ej_cnt = 0; plen = 0;
            end else begin
                if (Coin_Eject) begin
                    if (!ej_prev) ej_cnt++;
                    plen++;
                end else if (ej_prev) begin
                    if (plen_q.size() == 0) check("eject_pulse_unexpected", plen, 0);
                    else check("eject_pulse_len", plen, plen_q.pop_front());
                    plen = 0;
                end
                if (Done || (Jam && !jam_prev)) begin
                    check("done_jam_exclusive", int'(Done && Jam), 0);
                    if (exp_q.size() == 0) begin
                        check("completion_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("end_jam",       int'(Jam),       int'(e[EW-1]));
                        check("end_ejects",    ej_cnt,          int'(e[2*WIDTH+7:2*WIDTH]));
                        check("end_paid",      int'(Paid),      int'(e[2*WIDTH-1:WIDTH]));
                        check("end_remaining", int'(Remaining), int'(e[WIDTH-1:0]));
                    end
                    ej_cnt = 0;
                end
                ej_prev  = Coin_Eject;
                jam_prev = Jam;
            end
        end
    end

    // ---------------- transaction driver ----------------
    task automatic run_txn(input int amt, input bit hop, input bit inject);
        bit jam;
        int paid, rem, ej, cyc;
        bit seen;
        model(amt, hop, jam, paid, rem, ej);
        last_paid = paid;
        exp_q.push_back({jam, 8'(ej), WIDTH'(paid), WIDTH'(rem)});
        foreach (cur_plan[i]) plan_q.push_back(cur_plan[i]);
        @(negedge Clock);
        Hopper_Empty  = hop;
        Change_Amount = WIDTH'(amt);
        Change_Valid  = 1'b1;
        @(negedge Clock);
        Change_Valid = 1'b0;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 2000) begin
            if (Done || Jam) begin
                seen = 1;
            end else begin
                // A request while busy must be dropped without effect.
                if (inject && Busy && $urandom_range(0, 7) == 0) begin
                    Change_Valid  = 1'b1;
                    Change_Amount = WIDTH'(5);
                    inject        = 0;
                end
                @(negedge Clock);
                Change_Valid = 1'b0;
                cyc++;
            end
        end
        if (!seen) check("txn_timeout", 0, 1);
        if (amt == 0 || hop) check("immediate_latency", cyc, 0);
        if (hop && amt != 0) check("no_eject_on_empty", int'(Coin_Eject), 0);
        if (Jam) begin
            repeat (2) @(negedge Clock);
            check("jam_busy",      int'(Busy),       1);
            check("jam_eject_off", int'(Coin_Eject), 0);
            check("jam_hold_rem",  int'(Remaining),  rem);
            Jam_Clear    = 1'b1;
            Hopper_Empty = 1'b0;
            @(negedge Clock);
            Jam_Clear = 1'b0;
            check("clear_jam",       int'(Jam),       0);
            check("clear_busy",      int'(Busy),      0);
            check("clear_remaining", int'(Remaining), 0);
            check("clear_no_done",   int'(Done),      0);
            check("clear_paid_hold", int'(Paid),      paid);
        end else if (seen) begin
            @(negedge Clock);
            check("done_one_cycle", int'(Done), 0);
            check("idle_busy",      int'(Busy), 0);
        end
        plan_q.delete();
        cur_plan.delete();
        Hopper_Empty = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_eject"},     int'(Coin_Eject), 0);
        check({tag, "_busy"},      int'(Busy),       0);
        check({tag, "_done"},      int'(Done),       0);
        check({tag, "_jam"},       int'(Jam),        0);
        check({tag, "_remaining"}, int'(Remaining),  0);
        check({tag, "_paid"},      int'(Paid),       0);
        check({tag, "_state"},     int'(Fsm_State),  0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stimulus
        int cyc;
        int amt;
        bit hop;
        Change_Valid  = 1'b0;
        Change_Amount = '0;
        Hopper_Empty  = 1'b0;
        Jam_Clear     = 1'b0;
        nReset        = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_values("reset");
        nReset = 1'b1;
        @(negedge Clock);

        // Sensor edge while idle is ignored.
        #1 Coin_Sense = 1'b1;
        repeat (2) @(negedge Clock);
        check("idle_sense_paid", int'(Paid), 0);
        check("idle_sense_busy", int'(Busy), 0);

        // Normal payout of 3, coin lands 2 cycles after each eject falls,
        // plus a dropped request of 5 while busy.
        repeat (3) add_attempt(0, 0, 3);
        run_txn(3, 0, 1);

        // Zero request.
        run_txn(0, 0, 0);

        // Retry then jam on coin 2.
        add_attempt(0, 0, 3);
        add_attempt(1, 0, 0);
        add_attempt(1, 0, 0);
        run_txn(2, 0, 0);

        // Retry recovered: coin lands during the second eject.
        add_attempt(1, 0, 0);
        add_attempt(0, 0, 0);
        run_txn(1, 0, 0);

        // Hopper empty at request.
        run_txn(4, 1, 0);

        // Hopper goes empty during the gap after coin 1.
        add_attempt(0, 1, 3);
        add_attempt(0, 0, 3);
        add_attempt(0, 0, 3);
        run_txn(3, 0, 0);

        // Coin sensed on the last cycle before timeout.
        repeat (2) add_attempt(0, 0, EJECT_LEN + TIMEOUT - 1);
        run_txn(2, 0, 0);

        // Largest request, every coin lands on the first eject cycle.
        repeat (31) add_attempt(0, 0, 0);
        run_txn(31, 0, 0);

        // Reset in the middle of the second eject.
        repeat (3) add_attempt(0, 0, 3);
        foreach (cur_plan[i]) plan_q.push_back(cur_plan[i]);
        plen_q.push_back(EJECT_LEN);
        @(negedge Clock);
        Change_Amount = WIDTH'(3);
        Change_Valid  = 1'b1;
        @(negedge Clock);
        Change_Valid = 1'b0;
        cyc = 0;
        while (!(Coin_Eject && Remaining == WIDTH'(2)) && cyc < 200) begin
            @(negedge Clock);
            cyc++;
        end
        check("reach_second_eject", int'(Coin_Eject && Remaining == WIDTH'(2)), 1);
        #2 nReset = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge Clock);
        plan_q.delete();
        plen_q.delete();
        cur_plan.delete();
        last_paid    = 0;
        Hopper_Empty = 1'b0;
        nReset       = 1'b1;
        @(negedge Clock);
        add_attempt(0, 0, 1);
        run_txn(1, 0, 0);

        // Randomized payouts.
        repeat (40) begin
            amt = $urandom_range(0, 6);
            hop = ($urandom_range(0, 9) == 0);
            gen_plan(amt, 1);
            run_txn(amt, hop, $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge Clock);
        check("exp_queue_drained",  exp_q.size(),  0);
        check("plen_queue_drained", plen_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin hopper controller on the far end of the vending controller's change interface.
- Accepts a change amount in coin units and ejects that many coins, one pulse per coin.
- Confirms each coin through a chute sensor, retries on a missed coin, and declares a jam after repeated misses.
- Reports progress and completion back to the vending controller.

Parameters:
- WIDTH, 5: width of change amount and counters, in coin units.
- EJECT_LEN, 2: cycles Coin_Eject is held high per attempt (≥1).
- TIMEOUT, 8: cycles allowed in WAIT_SENSE for a coin to be sensed (≥1).
- GAP_LEN, 1: idle cycles between a sensed coin and the next eject (≥1).
- MAX_RETRY, 2: eject attempts allowed per coin before declaring a jam (≥1).

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Change_Valid  in  1  one-cycle request; samples Change_Amount.
- Change_Amount  in  WIDTH  number of coins to pay out.
- Coin_Sense  in  1  chute sensor, already synchronised; a 0→1 edge is one coin.
- Hopper_Empty  in  1  level; hopper has no coins.
- Jam_Clear  in  1  one-cycle operator clear of the jam condition.
- Coin_Eject  out  1  eject solenoid drive.
- Busy  out  1  payout in progress or jammed.
- Done  out  1  one-cycle pulse when payout is complete.
- Jam  out  1  jam or empty fault latched.
- Remaining  out  WIDTH  coins still owed.
- Paid  out  WIDTH  coins sensed in the current payout.

Behaviour:
- All outputs and state are registered. Reset is asynchronous, active-low, and may assert at any time.
- Reset values: state IDLE; Coin_Eject, Busy, Done, Jam = 0; Remaining, Paid = 0; timer, retry count, and sense edge register = 0.
- Sense edge: an edge is Coin_Sense high with the registered previous value low.
- States: IDLE, EJECT, WAIT_SENSE, GAP, JAM.
- IDLE:
  - Change_Valid with Change_Amount ≠ 0 at edge k: after edge k, state = EJECT, Busy = 1, Remaining = Change_Amount, Paid = 0, retry = 0, Coin_Eject = 1.
  - Change_Valid with Change_Amount = 0: Done = 1 for one cycle; Busy stays 0.
  - Sense edges in IDLE are ignored.
- Change_Valid while Busy = 1 is ignored; no queueing.
- Hopper_Empty check on every transition into EJECT: if Hopper_Empty = 1, go to JAM instead; Jam = 1, Coin_Eject stays 0.
- EJECT: Coin_Eject = 1 for exactly EJECT_LEN cycles, then WAIT_SENSE with timer cleared; Coin_Eject drops with the transition.
- Sense edge in EJECT or WAIT_SENSE:
  - Remaining -= 1, Paid += 1, retry = 0, Coin_Eject = 0.
  - If Remaining was 1: go to IDLE, Busy = 0, Done = 1 for one cycle.
  - Otherwise: go to GAP for GAP_LEN cycles, then EJECT.
- A sense edge and a timeout in the same cycle: the sense edge wins.
- Timeout: the timer reaches TIMEOUT−1 in WAIT_SENSE without a sense edge.
  - retry += 1.
  - If the new retry < MAX_RETRY: re-enter EJECT for the same coin.
  - Otherwise: go to JAM, Jam = 1.
- Sense edges in GAP or JAM are ignored; they never change Remaining or Paid.
- JAM:
  - Busy = 1, Coin_Eject = 0; Remaining and Paid hold for readout.
  - Jam_Clear: go to IDLE; Jam = 0, Busy = 0, Remaining = 0, retry = 0; Paid holds; no Done pulse.
- Arithmetic: Remaining never underflows, because a decrement happens only when Remaining ≥ 1. Paid ≤ Remaining at load, so it never wraps.
- Done and Jam are never both 1.

Test Plan:
- Normal payout: Change_Amount = 3, sense edge 2 cycles after each Coin_Eject fall → three Coin_Eject pulses of 2 cycles each; Remaining steps 3→2→1→0; Paid = 3; one Done pulse; Busy returns to 0.
- Zero request and ignored request: Change_Amount = 0 → Done pulse the next cycle and no Coin_Eject. Change_Valid with amount 5 while Busy → Remaining unaffected.
- Retry then jam: amount 2, first coin sensed, second coin never sensed → two attempts for coin 2, each 2 + 8 cycles. Then Jam = 1, Remaining = 1, Paid = 1. Jam_Clear → IDLE with Remaining = 0, Busy = 0, and no Done.
- Retry recovered: amount 1, no sense on attempt 1, sense during attempt 2's EJECT → Paid = 1, Done pulse, Jam stays 0.
- Hopper empty: Hopper_Empty = 1 at request (amount 4) → Jam = 1 immediately with no Coin_Eject. Separately, Hopper_Empty rising during GAP → JAM at the next EJECT entry with Remaining preserved.
- Reset mid-payout: nReset low during EJECT with Remaining = 2 → Coin_Eject drops asynchronously and all outputs take reset values. After release, a new request with amount 1 completes normally.
